// File: rtl/stopwatch_core_if.sv
// -----------------------------------------------------------------------------
// stopwatch_core_if
// Bundles the command input and the display/status outputs of the stopwatch
// core.
//   state              3  command code from the button block (level)
//   cs_ones, cs_tens   4  centisecond BCD digits
//   sec_ones, sec_tens 4  seconds BCD digits
//   min_ones, min_tens 4  minutes BCD digits
//   running/paused/stopped  FSM status flags (all low in IDLE)
//   overflow           1  sticky, time wrapped past 59:59.99
//   tick               1  one-cycle pulse when the digits change
// master: the side issuing commands and reading the display.
// slave : the stopwatch core.
// -----------------------------------------------------------------------------
interface stopwatch_core_if;
   logic [2:0] state;
   logic [3:0] cs_ones;
   logic [3:0] cs_tens;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
   logic [3:0] min_tens;
   logic       running;
   logic       paused;
   logic       stopped;
   logic       overflow;
   logic       tick;

   modport master (
      output state,
      input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
      input  running, paused, stopped, overflow, tick
   );

   modport slave (
      input  state,
      output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
      output running, paused, stopped, overflow, tick
   );
endinterface

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// MM:SS.CC stopwatch. Decodes the button command level into an
// IDLE/RUN/PAUSE/STOPPED machine, divides the clock down to TICK_HZ and keeps
// the time as six BCD digits.
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of stopwatch_core_if (command in, digits/flags out)
// -----------------------------------------------------------------------------
module stopwatch_core #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 100
) (
   input  logic              clk,
   input  logic              reset,
   stopwatch_core_if.slave   bus
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   localparam logic [2:0] CMD_RESET = 3'b001;
   localparam logic [2:0] CMD_COUNT = 3'b010;
   localparam logic [2:0] CMD_PAUSE = 3'b011;
   localparam logic [2:0] CMD_STOP  = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_STOPPED} fsm_t;

   fsm_t          r_fsm, w_fsm_next;
   logic [PW-1:0] r_pre, w_pre_next;
   logic [3:0]    r_cs_ones, r_cs_tens, r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
   logic          r_overflow;
   logic          r_tick;

   logic w_cmd_reset;
   logic w_pre_wrap;
   logic w_inc;
   logic w_c1, w_c2, w_c3, w_c4, w_c5, w_wrap;

   // One BCD digit: advance when enabled, rolling over at lim.
   function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic [3:0] lim,
                                           input logic en);
      if (!en) return d;
      return (d == lim) ? 4'd0 : d + 4'd1;
   endfunction

   assign w_cmd_reset = (bus.state == CMD_RESET);
   // The FSM as registered at the start of the edge decides whether the
   // prescaler runs, so PAUSE/STOP on a wrap edge still take the increment.
   assign w_pre_wrap  = (r_fsm == S_RUN) && (r_pre == PRE_LAST);
   // A RESET code on the wrap edge discards the increment.
   assign w_inc       = w_pre_wrap && !w_cmd_reset;

   // Ripple carry through the digit chain.
   assign w_c1   = w_inc && (r_cs_ones  == 4'd9);
   assign w_c2   = w_c1  && (r_cs_tens  == 4'd9);
   assign w_c3   = w_c2  && (r_sec_ones == 4'd9);
   assign w_c4   = w_c3  && (r_sec_tens == 4'd5);
   assign w_c5   = w_c4  && (r_min_ones == 4'd9);
   assign w_wrap = w_c5  && (r_min_tens == 4'd5);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      w_fsm_next = r_fsm;
      w_pre_next = r_pre;
      if (r_fsm == S_RUN) w_pre_next = w_pre_wrap ? '0 : r_pre + 1'b1;

      case (r_fsm)
         S_IDLE:    if (bus.state == CMD_COUNT) w_fsm_next = S_RUN;
         S_RUN: begin
            if (bus.state == CMD_PAUSE)     w_fsm_next = S_PAUSE;
            else if (bus.state == CMD_STOP) w_fsm_next = S_STOPPED;
         end
         S_PAUSE: begin
            if (bus.state == CMD_COUNT)     w_fsm_next = S_RUN;
            else if (bus.state == CMD_STOP) w_fsm_next = S_STOPPED;
         end
         S_STOPPED: w_fsm_next = S_STOPPED;   // only RESET leaves
         default:   w_fsm_next = S_IDLE;
      endcase
      if (w_cmd_reset) w_fsm_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) r_fsm <= S_IDLE;
      else       r_fsm <= w_fsm_next;
   end

   // Digits are reloaded every edge from their next value (which equals the
   // current value when no increment happens).
   always_ff @(posedge clk or posedge reset) begin
      if (reset || w_cmd_reset) begin
         r_pre      <= '0;
         r_cs_ones  <= 4'd0;
         r_cs_tens  <= 4'd0;
         r_sec_ones <= 4'd0;
         r_sec_tens <= 4'd0;
         r_min_ones <= 4'd0;
         r_min_tens <= 4'd0;
         r_overflow <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_pre      <= w_pre_next;
         r_cs_ones  <= bcd_step(r_cs_ones,  4'd9, w_inc);
         r_cs_tens  <= bcd_step(r_cs_tens,  4'd9, w_c1);
         r_sec_ones <= bcd_step(r_sec_ones, 4'd9, w_c2);
         r_sec_tens <= bcd_step(r_sec_tens, 4'd5, w_c3);
         r_min_ones <= bcd_step(r_min_ones, 4'd9, w_c4);
         r_min_tens <= bcd_step(r_min_tens, 4'd5, w_c5);
         r_overflow <= r_overflow | w_wrap;
         r_tick     <= w_inc;
      end
   end

   assign bus.cs_ones  = r_cs_ones;
   assign bus.cs_tens  = r_cs_tens;
   assign bus.sec_ones = r_sec_ones;
   assign bus.sec_tens = r_sec_tens;
   assign bus.min_ones = r_min_ones;
   assign bus.min_tens = r_min_tens;
   assign bus.running  = (r_fsm == S_RUN);
   assign bus.paused   = (r_fsm == S_PAUSE);
   assign bus.stopped  = (r_fsm == S_STOPPED);
   assign bus.overflow = r_overflow;
   assign bus.tick     = r_tick;

endmodule

// File: tb/tb_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_core
// Drives command codes into stopwatch_core (DIV = 10) and compares every cycle
// against a behavioural model that keeps time as a plain centisecond count.
// Expected snapshots are queued when a command is driven and popped after the
// clock edge that produces them.
// -----------------------------------------------------------------------------
module tb_stopwatch_core;

   localparam int DIV      = 10;
   localparam int FULL_CS  = 360000;   // 60 minutes in centiseconds

   typedef struct packed {
      logic [23:0] digits;   // {min_tens,min_ones,sec_tens,sec_ones,cs_tens,cs_ones}
      logic        running;
      logic        paused;
      logic        stopped;
      logic        overflow;
      logic        tick;
   } snap_t;

   logic clk;
   logic reset;
   stopwatch_core_if sw_if ();

   stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sw_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   snap_t sb_q[$];

   // Model state: 0 IDLE, 1 RUN, 2 PAUSE, 3 STOPPED
   int   m_fsm, m_pre, m_time;
   logic m_ovf, m_tick;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] model_digits();
      int cs, s, m;
      cs = m_time % 100;
      s  = (m_time / 100) % 60;
      m  = m_time / 6000;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s.digits   = model_digits();
      s.running  = (m_fsm == 1);
      s.paused   = (m_fsm == 2);
      s.stopped  = (m_fsm == 3);
      s.overflow = m_ovf;
      s.tick     = m_tick;
      return s;
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.digits   = {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones,
                    sw_if.cs_tens, sw_if.cs_ones};
      s.running  = sw_if.running;
      s.paused   = sw_if.paused;
      s.stopped  = sw_if.stopped;
      s.overflow = sw_if.overflow;
      s.tick     = sw_if.tick;
      return s;
   endfunction

   task automatic model_clear();
      m_fsm = 0; m_pre = 0; m_time = 0; m_ovf = 1'b0; m_tick = 1'b0;
   endtask

   task automatic model_step(input logic [2:0] cmd);
      logic inc;
      if (cmd == 3'b001) begin
         model_clear();
         return;
      end
      inc = (m_fsm == 1) && (m_pre == DIV - 1);
      if (m_fsm == 1) m_pre = inc ? 0 : m_pre + 1;
      m_tick = inc;
      if (inc) begin
         m_time++;
         if (m_time == FULL_CS) begin
            m_time = 0;
            m_ovf  = 1'b1;
         end
      end
      case (m_fsm)
         0: if (cmd == 3'b010) m_fsm = 1;
         1: if (cmd == 3'b011) m_fsm = 2; else if (cmd == 3'b100) m_fsm = 3;
         2: if (cmd == 3'b010) m_fsm = 1; else if (cmd == 3'b100) m_fsm = 3;
         default: ;
      endcase
   endtask

   // Drive one command for one clock edge and score the result.
   task automatic cycle(input logic [2:0] cmd);
      snap_t exp_s;
      @(negedge clk);
      sw_if.state = cmd;
      if (reset) model_clear();
      else       model_step(cmd);
      sb_q.push_back(model_snap());
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         exp_s = sb_q.pop_front();
         check("cycle", 32'(dut_snap()), 32'(exp_s));
      end
   endtask

   task automatic run(input logic [2:0] cmd, input int n);
      for (int i = 0; i < n; i++) cycle(cmd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, ticks;
      logic prev_tick;
      snap_t s;

      reset = 1'b1;
      sw_if.state = 3'b000;
      model_clear();
      run(3'b000, 2);
      check("por_state", 32'(dut_snap()), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // 1: async reset mid-count at 00:03.47
      cycle(3'b010);
      n = 0;
      while (m_time != 347 && n < 4000) begin cycle(3'b010); n++; end
      check("t1_reach_347", dut_snap().digits, 24'h000347);
      #2;
      reset = 1'b1;
      #1;
      check("t1_async_rst", 32'(dut_snap()), 32'd0);
      model_clear();
      run(3'b000, 2);
      @(negedge clk);
      reset = 1'b0;
      run(3'b000, 20);
      check("t1_after_rel", 32'(dut_snap()), 32'd0);

      // 2: count from IDLE
      cycle(3'b010);
      check("t2_running", sw_if.running, 1'b1);
      run(3'b010, 10);
      check("t2_cs01", dut_snap().digits, 24'h000001);
      ticks = 0;
      prev_tick = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         cycle(3'b010);
         if (sw_if.tick) ticks++;
         if (sw_if.tick && prev_tick) check("t2_tick_width", 32'd2, 32'd1);
         prev_tick = sw_if.tick;
      end
      check("t2_tick_count", ticks, 100);
      check("t2_time_1_01", dut_snap().digits, 24'h000101);

      // 3: pause with the prescaler held at 4, resume latency
      n = 0;
      while (m_pre != 3 && n < 20) begin cycle(3'b010); n++; end
      cycle(3'b011);
      check("t3_paused", sw_if.paused, 1'b1);
      run(3'b011, 50);
      check("t3_frozen", dut_snap().digits, 24'h000101);
      cycle(3'b010);
      check("t3_rerun", sw_if.running, 1'b1);
      n = 0;
      do begin cycle(3'b010); n++; end while (!sw_if.tick && n < 20);
      check("t3_resume_lat", n, 6);

      // 4: stop freezes time, only RESET leaves
      cycle(3'b001);
      cycle(3'b010);
      n = 0;
      while (m_time != 25 && n < 400) begin cycle(3'b010); n++; end
      cycle(3'b100);
      check("t4_stopped", sw_if.stopped, 1'b1);
      run(3'b010, 30);
      run(3'b011, 30);
      check("t4_frozen", dut_snap().digits, 24'h000025);
      check("t4_still_stop", sw_if.stopped, 1'b1);
      cycle(3'b001);
      check("t4_cleared", 32'(dut_snap()), 32'd0);

      // 5: preload to 59:59.98 while paused, then run through the wrap
      cycle(3'b010);
      run(3'b010, 3);
      cycle(3'b011);
      force dut.r_min_tens = 4'd5;
      force dut.r_min_ones = 4'd9;
      force dut.r_sec_tens = 4'd5;
      force dut.r_sec_ones = 4'd9;
      force dut.r_cs_tens  = 4'd9;
      force dut.r_cs_ones  = 4'd8;
      m_time = FULL_CS - 2;
      cycle(3'b011);
      release dut.r_min_tens;
      release dut.r_min_ones;
      release dut.r_sec_tens;
      release dut.r_sec_ones;
      release dut.r_cs_tens;
      release dut.r_cs_ones;
      check("t5_preload", dut_snap().digits, 24'h595998);
      cycle(3'b010);
      ticks = 0;
      n = 0;
      while (ticks < 2 && n < 40) begin
         cycle(3'b010);
         if (sw_if.tick) ticks++;
         n++;
      end
      check("t5_wrap_time", dut_snap().digits, 24'h000000);
      check("t5_overflow", sw_if.overflow, 1'b1);
      run(3'b010, 30);
      check("t5_continues", dut_snap().digits, 24'h000003);
      check("t5_ovf_sticky", sw_if.overflow, 1'b1);
      cycle(3'b001);
      check("t5_ovf_clear", sw_if.overflow, 1'b0);

      // 6: RESET on the wrap edge wins; undefined codes are no-ops
      cycle(3'b010);
      n = 0;
      while (!(m_time == 9 && m_pre == DIV - 1) && n < 200) begin cycle(3'b010); n++; end
      check("t6_at_009", dut_snap().digits, 24'h000009);
      cycle(3'b001);
      check("t6_rst_on_wrap", 32'(dut_snap()), 32'd0);
      cycle(3'b010);
      run(3'b010, 15);
      run(3'b101, 20);
      run(3'b111, 20);
      s = dut_snap();
      check("t6_nop_time", s.digits, 24'h000005);
      check("t6_nop_running", s.running, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
